// File: rtl/piso_pkg.sv
// piso_pkg: shared types and sizing helpers for the piso_ctrl serializer.
//   state_e     : controller state (IDLE waiting for a word, SHIFT sending bits)
//   cnt_width() : width of the bit counter for a given data width
//   nbits()     : bits per frame (data bits plus optional parity bit)
// Optional feature macro: PISO_PARITY_EN (appends one even-parity bit per frame).
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Counter must be able to hold WIDTH (the parity-bit index when enabled).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int nbits(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: WIDTH-bit parallel-load shift register with a selectable
// shift direction. Zeros are shifted in behind the data.
//   clk_i   : rising-edge clock
//   reset_i : synchronous active-high reset, clears the register
//   load_i  : load d_i (takes priority over shift_i)
//   shift_i : advance the register by one bit
//   d_i     : parallel word
//   head_o  : bit currently at the output end (MSB when MSB_FIRST, else LSB)
// Optional feature macro: PISO_PARITY_EN (not used in this file).
module piso_shreg
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             head_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next register contents: load, shift toward the output end, or hold.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
      end else begin
        data_d = {1'b0, data_q[WIDTH-1:1]};
      end
    end else begin
      data_d = data_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign head_o = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/piso_ctrl.sv
// piso_ctrl: parallel-in serial-out controller. Accepts words over a
// valid/ready handshake and sends them one bit per cycle to a sink that
// may stall; back-to-back frames are sent without an idle cycle.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   d_in      : parallel word from the requester
//   in_valid  : requester presents a word
//   in_ready  : word is accepted this cycle (combinational from state)
//   ser_ready : sink accepts ser_out this cycle
//   ser_out   : current serial bit
//   ser_valid : ser_out carries a frame bit
//   ser_last  : ser_out is the final bit of the frame
//   busy      : frame in progress
// Optional feature macro: PISO_PARITY_EN (even-parity bit appended after data).
module piso_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int             NBITS    = nbits(WIDTH);
  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(NBITS - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic in_shift_s;
  logic last_s;
  logic xfer_s;
  logic accept_s;
  logic shift_en_s;
  logic head_s;
  logic bit_s;

  assign in_shift_s = (state_q == SHIFT);
  assign last_s     = in_shift_s & (cnt_q == LAST_CNT);
  assign xfer_s     = in_shift_s & ser_ready;
  assign in_ready   = (state_q == IDLE) | (last_s & ser_ready);
  assign accept_s   = in_valid & in_ready;
  // A reload on the final transfer replaces the shift on that edge.
  assign shift_en_s = xfer_s & ~accept_s;

  piso_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk_i  (clk),
    .reset_i(reset),
    .load_i (accept_s),
    .shift_i(shift_en_s),
    .d_i    (d_in),
    .head_o (head_s)
  );

`ifdef PISO_PARITY_EN
  logic parity_q;

  // Latch even parity of each accepted word for the trailing parity bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept_s) begin
      parity_q <= ^d_in;
    end else begin
      parity_q <= parity_q;
    end
  end

  assign bit_s = (cnt_q == CW'(WIDTH)) ? parity_q : head_s;
`else
  assign bit_s = head_s;
`endif

  assign ser_out   = in_shift_s & bit_s;
  assign ser_valid = in_shift_s;
  assign busy      = in_shift_s;
  assign ser_last  = last_s;

  // Next-state and bit-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SHIFT;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (xfer_s) begin
          if (last_s) begin
            // Frame end: reload and continue, or fall back to IDLE.
            cnt_d = {CW{1'b0}};
            if (in_valid) begin
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and counter registers; reset overrides accept and transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/piso_ctrl.md
Name: piso_ctrl

Overview:
- Serializer controller that accepts parallel words from an upstream requester over a valid/ready handshake.
- Loads each word into a resettable parallel-load shift register and sequences it out one bit per cycle to a downstream sink that can stall.
- Sits between parallel datapath registers and a serial link.
- Supports gapless back-to-back frames.

Parameters:
- WIDTH, 4, number of data bits per frame (must be ≥ 2).
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- d_in  input  WIDTH  parallel word from requester
- in_valid  input  1  requester has a word on d_in
- in_ready  output  1  controller will accept d_in this cycle
- ser_ready  input  1  sink accepts ser_out this cycle
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out holds a frame bit
- ser_last  output  1  ser_out is the final bit of the frame
- busy  output  1  frame in progress (state SHIFT)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. Reset is sampled only on the rising clk edge.
- Reset values: state=IDLE, shift register=0, bit counter=0. Outputs: ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=1 (in_ready is combinational from state).
- State IDLE:
  - in_ready=1, ser_valid=0.
  - Accept when in_valid&in_ready: capture d_in, set cnt=0, go to SHIFT.
- State SHIFT:
  - ser_valid=1, busy=1.
  - ser_out = current head bit: MSB when MSB_FIRST=1, else LSB.
  - Bit transfer occurs when ser_valid&ser_ready: shift the register by one and increment cnt.
  - ser_ready=0 stalls the controller: shift register, cnt, ser_out and ser_last all hold.
  - ser_last=1 when cnt==NBITS-1. NBITS=WIDTH, or WIDTH+1 with parity enabled.
- Frame end (last-bit transfer):
  - in_valid=1 → load the new word, cnt=0, stay in SHIFT. No idle bubble.
  - in_valid=0 → go to IDLE.
- in_ready = (state==IDLE) | (state==SHIFT & ser_last & ser_ready).
  - in_valid asserted during a non-final bit is ignored and the word is not consumed.
  - The requester must hold d_in stable until in_ready.
- Latency:
  - Word accepted at edge k; first bit valid on ser_out from edge k to edge k+1.
  - An unstalled frame occupies exactly NBITS cycles.
- Counter width: clog2(WIDTH+1). Never exceeds NBITS-1.
- Reset mid-frame discards the remaining bits. The next cycle is IDLE with ser_valid=0.
- Reset has priority over simultaneous accept and transfer.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - On load, even parity of d_in (XOR reduction) is latched.
  - After the WIDTH data bits, one extra parity bit is sent; ser_last is asserted on it.
  - NBITS=WIDTH+1.
- Undefined:
  - No parity logic; NBITS=WIDTH.
  - ser_last is asserted on data bit WIDTH-1 of the sequence.

Decomposition:
- Package piso_pkg:
  - state enum {IDLE, SHIFT}
  - function cnt_width(WIDTH)
  - localparam helpers for NBITS
- Sub-module piso_shreg: WIDTH-bit register with synchronous active-high reset (forces 0), parallel load, shift enable and a direction parameter. The top level owns the FSM, counter, handshake and parity.

Test Plan:
- WIDTH=4, MSB_FIRST=1, ser_ready=1, accept 4'b1011 → ser_out 1,0,1,1 on 4 consecutive cycles; ser_last on the 4th; ser_valid=0 on the 5th.
- Back-to-back: 4'hA then 4'h5, with the second in_valid held from the start → in_ready pulses on last bit → 8 contiguous bits 1,0,1,0,0,1,0,1 with no ser_valid gap.
- Stall: accept 4'b1001; ser_ready=0 for 3 cycles when the 2nd bit is presented → ser_out holds 0 and ser_last stays 0 for 3 cycles; the frame completes 1,0,0,1 in 7 cycles total.
- Reset mid-frame: assert reset after 2 bits of 4'hF → next cycle ser_valid=0, busy=0, in_ready=1; a following 4'h3 serializes as 0,0,1,1.
- in_valid pulsed during bit 1 of a frame with d_in=4'h6 → not consumed; the frame is unchanged; ser_valid drops after the frame.
- PISO_PARITY_EN defined, accept 4'b0111 → 0,1,1,1,1 with ser_last on the 5th bit; with MSB_FIRST=0 and 4'b0011 → 1,1,0,0,0.
